// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs field-level instructions into 16-bit ISA words and streams them into program memory
module instruction_encoder #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_address,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic [3:0]           in_rt,
  input  logic [2:0]           in_nzp,
  input  logic [7:0]           in_immediate,
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS:0]   word_count
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_BITS-1:0] base_reg;
  logic [ADDR_BITS:0]   push_count;
  logic [ADDR_BITS:0]   next_push_addr;
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [PTR_BITS:0]    fifo_count;
  logic                 fifo_empty, fifo_full;
  logic                 accept, legal, is_ret, overflow, push, pop, start_ok;
  logic [DATA_BITS-1:0] encoded;

  function automatic logic [DATA_BITS-1:0] encode(
    input logic [3:0] op, rd, rs, rt,
    input logic [2:0] nzp,
    input logic [7:0] imm
  );
    case (op)
      4'h1:                   encode = {4'h1, nzp, 1'b0, imm};
      4'h2:                   encode = {4'h2, 4'h0, rs, rt};
      4'h3, 4'h4, 4'h5, 4'h6: encode = {op, rd, rs, rt};
      4'h7:                   encode = {4'h7, rd, rs, 4'h0};
      4'h8:                   encode = {4'h8, 4'h0, rs, rt};
      4'h9:                   encode = {4'h9, rd, imm};
      4'hF:                   encode = 16'hF000;
      default:                encode = 16'h0000;
    endcase
  endfunction

  assign encoded    = encode(in_opcode, in_rd, in_rs, in_rt, in_nzp, in_immediate);
  assign legal      = !(in_opcode >= 4'hA && in_opcode <= 4'hE);
  assign is_ret     = (in_opcode == 4'hF);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);

  // Address the incoming word would occupy; a carry out means it falls off the end of memory.
  assign next_push_addr = {1'b0, base_reg} + push_count;
  assign overflow       = next_push_addr[ADDR_BITS];

  assign in_ready = (state == S_LOAD) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal && !overflow;
  assign pop      = !fifo_empty && mem_write_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  assign mem_write_valid   = !fifo_empty;
  assign mem_write_address = base_reg + word_count[ADDR_BITS-1:0];
  assign mem_write_data    = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign busy              = (state == S_LOAD) || (state == S_DRAIN);
  assign done              = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD:         if (accept && (is_ret || (legal && overflow))) state_next = S_DRAIN;
      S_DRAIN:        if (fifo_empty) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg   <= '0;
      push_count <= '0;
      word_count <= '0;
      error      <= 1'b0;
    end else if (start_ok) begin
      base_reg   <= base_address;
      push_count <= '0;
      word_count <= '0;
      error      <= 1'b0;
    end else begin
      if (accept && (!legal || overflow)) error <= 1'b1;
      if (push) push_count <= push_count + 1'b1;
      if (pop)  word_count <= word_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= encoded;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_address;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
  logic [2:0]  in_nzp;
  logic [7:0]  in_immediate;
  logic        mem_write_valid;
  logic        mem_write_ready;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        busy, done, error;
  logic [8:0]  word_count;

  int errors = 0;
  int checks = 0;
  int k;
  logic acc;

  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  logic [15:0] exp_d[$];

  instruction_encoder dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_rd             (in_rd),
    .in_rs             (in_rs),
    .in_rt             (in_rt),
    .in_nzp            (in_nzp),
    .in_immediate      (in_immediate),
    .mem_write_valid   (mem_write_valid),
    .mem_write_ready   (mem_write_ready),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .word_count        (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && mem_write_valid && mem_write_ready) begin
      wa.push_back(mem_write_address);
      wd.push_back(mem_write_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] op, rd, rs, rt, input logic [2:0] nzp, input logic [7:0] imm);
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_nzp = nzp; in_immediate = imm;
  endtask

  task automatic send(input logic [3:0] op, rd, rs, rt, input logic [2:0] nzp, input logic [7:0] imm);
    int n;
    n = 0;
    set_fields(op, rd, rs, rt, nzp, imm);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] b);
    wa.delete(); wd.delete(); exp_d.delete();
    base_address = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done", 32'(done), 32'd1);
  endtask

  task automatic check_writes(input logic [7:0] b);
    check("write_count", 32'(wa.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < wa.size()) begin
        check($sformatf("wr_addr[%0d]", i), 32'(wa[i]), 32'(8'(b + 8'(i))));
        check($sformatf("wr_data[%0d]", i), 32'(wd[i]), 32'(exp_d[i]));
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_address = '0; in_valid = 1'b0;
    mem_write_ready = 1'b1;
    set_fields(4'h0, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    repeat (2) @(negedge clk);

    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(mem_write_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_addr", 32'(mem_write_address), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic session with first-write latency
    start_session(8'h10);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_valid_before", 32'(mem_write_valid), 32'd0);
    send(4'h9, 4'h2, 4'h7, 4'h7, 3'h7, 8'h5A);
    check("t1_latency_valid", 32'(mem_write_valid), 32'd1);
    check("t1_latency_addr", 32'(mem_write_address), 32'h10);
    check("t1_latency_data", 32'(mem_write_data), 32'h925A);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h7, 8'hFF);
    send(4'hF, 4'h5, 4'h5, 4'h5, 3'h5, 8'h55);
    wait_done();
    exp_d = '{16'h925A, 16'h3123, 16'hF000};
    check_writes(8'h10);
    check("t1_word_count", 32'(word_count), 32'd3);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd0);

    // 2: remaining encodings with unused fields carrying junk
    start_session(8'h20);
    send(4'h1, 4'hF, 4'hF, 4'hF, 3'b101, 8'h07);
    send(4'h7, 4'h4, 4'h5, 4'h9, 3'h7, 8'hFF);
    send(4'h8, 4'h7, 4'h5, 4'h6, 3'h7, 8'hFF);
    send(4'h2, 4'h3, 4'h1, 4'h2, 3'h7, 8'hFF);
    send(4'hF, 4'h1, 4'h2, 4'h3, 3'h1, 8'h01);
    wait_done();
    exp_d = '{16'h1A07, 16'h7450, 16'h8056, 16'h2012, 16'hF000};
    check_writes(8'h20);
    check("t2_word_count", 32'(word_count), 32'd5);

    // 3: backpressure with continuous input
    start_session(8'h30);
    mem_write_ready = 1'b0;
    k = 0;
    set_fields(4'h3, 4'h0, 4'h1, 4'h2, 3'h0, 8'h00);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) begin
        k++;
        set_fields(4'h3, 4'(k), 4'(k + 1), 4'(k + 2), 3'h0, 8'h00);
      end
      if (c == 5) begin
        check("t3_stall_addr_mid", 32'(mem_write_address), 32'h30);
        check("t3_stall_data_mid", 32'(mem_write_data), 32'h3012);
      end
    end
    check("t3_accepts", 32'(k), 32'd4);
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    check("t3_stall_addr_end", 32'(mem_write_address), 32'h30);
    check("t3_stall_data_end", 32'(mem_write_data), 32'h3012);
    check("t3_no_writes_stalled", 32'(wa.size()), 32'd0);
    in_valid = 1'b0;
    mem_write_ready = 1'b1;
    send(4'h3, 4'h4, 4'h5, 4'h6, 3'h0, 8'h00);
    send(4'h3, 4'h5, 4'h6, 4'h7, 3'h0, 8'h00);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    exp_d = '{16'h3012, 16'h3123, 16'h3234, 16'h3345, 16'h3456, 16'h3567, 16'hF000};
    check_writes(8'h30);
    check("t3_word_count", 32'(word_count), 32'd7);

    // 4: illegal opcode between two ADDs
    start_session(8'h40);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'hB, 4'h9, 4'h9, 4'h9, 3'h0, 8'h00);
    check("t4_error_set", 32'(error), 32'd1);
    check("t4_still_loading", 32'(in_ready), 32'd1);
    send(4'h3, 4'h4, 4'h5, 4'h6, 3'h0, 8'h00);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    exp_d = '{16'h3123, 16'h3456, 16'hF000};
    check_writes(8'h40);
    check("t4_word_count", 32'(word_count), 32'd3);
    check("t4_error", 32'(error), 32'd1);

    // 5: address overflow at the top of memory
    start_session(8'hFE);
    check("t5_error_cleared", 32'(error), 32'd0);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'h3, 4'h4, 4'h5, 4'h6, 3'h0, 8'h00);
    send(4'h3, 4'h7, 4'h8, 4'h9, 3'h0, 8'h00);
    wait_done();
    exp_d = '{16'h3123, 16'h3456};
    check_writes(8'hFE);
    check("t5_word_count", 32'(word_count), 32'd2);
    check("t5_error", 32'(error), 32'd1);

    // 6: reset mid-session with buffered words
    start_session(8'h50);
    mem_write_ready = 1'b0;
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'h3, 4'h4, 4'h5, 4'h6, 3'h0, 8'h00);
    check("t6_buffered_valid", 32'(mem_write_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(mem_write_valid), 32'd0);
    check("t6_rst_data", 32'(mem_write_data), 32'd0);
    check("t6_rst_addr", 32'(mem_write_address), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    mem_write_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wa.delete(); wd.delete();
    repeat (5) @(negedge clk);
    check("t6_no_writes_after", 32'(wa.size()), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    start_session(8'h60);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    exp_d = '{16'h3123, 16'hF000};
    check_writes(8'h60);
    check("t6_word_count", 32'(word_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
